kd_tree_traverse_pipe: RTL and testbench

//  Parametrised, pipelined KD-tree traversal engine; successor to the fixed 7-level internal-node tree.

---
 rtl/kd_tree_traverse_pipe.sv | 180 ++++++++++++++++++
 tb/tb_kd_tree_traverse_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kd_tree_traverse_pipe.sv
// Pipelined KD-tree traversal: heap-ordered node table, one level per stage, DEPTH-bit leaf out.
// Define KD_PATH_MARGIN_EN to add out_margin (min |e - median| along the taken path).
module kd_tree_traverse_pipe #(
    parameter int DEPTH      = 7,
    parameter int DIM        = 5,
    parameter int ELEM_WIDTH = 11,
    parameter int IDX_W      = 3,
    localparam int PATCH_WIDTH = DIM * ELEM_WIDTH,
    localparam int NODE_W      = IDX_W + ELEM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_restart,
    input  logic                   wr_en,
    input  logic [NODE_W-1:0]      wr_data,
    output logic                   load_done,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PATCH_WIDTH-1:0] in_patch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DEPTH-1:0]       out_leaf
`ifdef KD_PATH_MARGIN_EN
    ,
    output logic [ELEM_WIDTH-1:0]  out_margin
`endif
);

    localparam int NODES = (1 << DEPTH) - 1;

    logic [NODE_W-1:0]      node_q [NODES];
    logic [NODE_W-1:0]      node_d [NODES];
    logic [DEPTH-1:0]       wptr_q, wptr_d;
    logic                   load_done_q, load_done_d;

    logic [DEPTH-1:0]       vld_q, vld_d;
    logic [PATCH_WIDTH-1:0] patch_q [DEPTH];
    logic [PATCH_WIDTH-1:0] patch_d [DEPTH];
    logic [DEPTH-1:0]       path_q [DEPTH];
    logic [DEPTH-1:0]       path_d [DEPTH];

    logic [DEPTH-1:0]       src_vld;
    logic [PATCH_WIDTH-1:0] src_patch [DEPTH];
    logic [DEPTH-1:0]       src_path [DEPTH];
    logic [DEPTH-1:0]       go_right;
    logic                   stall;

`ifdef KD_PATH_MARGIN_EN
    logic [ELEM_WIDTH-1:0]  margin_q [DEPTH];
    logic [ELEM_WIDTH-1:0]  margin_d [DEPTH];
    logic [ELEM_WIDTH-1:0]  src_margin [DEPTH];
    logic [ELEM_WIDTH-1:0]  next_margin [DEPTH];
`endif

    assign stall     = vld_q[DEPTH-1] && !out_ready;
    assign in_ready  = load_done_q && !stall;
    assign load_done = load_done_q;
    assign out_valid = vld_q[DEPTH-1];
    assign out_leaf  = path_q[DEPTH-1];
`ifdef KD_PATH_MARGIN_EN
    assign out_margin = margin_q[DEPTH-1];
`endif

    // Serial node loader; load_restart beats a same-cycle write, and the pointer parks on the last node.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
        wptr_d      = wptr_q;
        load_done_d = load_done_q;
        node_d      = node_q;
        if (load_restart) begin
            wptr_d      = '0;
            load_done_d = 1'b0;
        end else if (wr_en && !load_done_q) begin
            node_d[wptr_q] = wr_data;
            if (wptr_q == DEPTH'(NODES - 1)) load_done_d = 1'b1;
            else                             wptr_d      = wptr_q + DEPTH'(1);
        end
    end

    always_comb begin
        src_vld[0]   = in_valid && in_ready;
        src_patch[0] = in_patch;
        src_path[0]  = '0;
        for (int l = 1; l < DEPTH; l++) begin
            src_vld[l]   = vld_q[l-1];
            src_patch[l] = patch_q[l-1];
            src_path[l]  = path_q[l-1];
        end
    end

`ifdef KD_PATH_MARGIN_EN
    always_comb begin
        src_margin[0] = '1;
        for (int l = 1; l < DEPTH; l++) src_margin[l] = margin_q[l-1];
    end
`endif

    // Stage l sees only level-l nodes: heap base 2^l-1 plus the path bits decided so far.
    for (genvar l = 0; l < DEPTH; l++) begin : g_stage
        logic [DEPTH-1:0]      addr;
        logic [NODE_W-1:0]     nd;
        logic [IDX_W-1:0]      dim;
        logic [ELEM_WIDTH-1:0] med;
        logic [ELEM_WIDTH-1:0] elem;
        logic                  dim_ok;

        assign addr = DEPTH'((1 << l) - 1) + src_path[l];
        assign nd   = node_q[addr];
        assign dim  = nd[NODE_W-1 -: IDX_W];
        assign med  = nd[ELEM_WIDTH-1:0];

        always_comb begin
            elem   = '0;
            dim_ok = 1'b0;
            for (int d = 0; d < DIM; d++) begin
                if (dim == IDX_W'(d)) begin
                    elem   = src_patch[l][d*ELEM_WIDTH +: ELEM_WIDTH];
                    dim_ok = 1'b1;
                end
            end
        end

        assign go_right[l] = dim_ok && (elem > med);

`ifdef KD_PATH_MARGIN_EN
        logic [ELEM_WIDTH-1:0] diff;
        assign diff = !dim_ok     ? '1 :
                      (elem > med) ? elem - med : med - elem;
        assign next_margin[l] = (diff < src_margin[l]) ? diff : src_margin[l];
`endif
    end

    always_comb begin
        vld_d   = vld_q;
        patch_d = patch_q;
        path_d  = path_q;
`ifdef KD_PATH_MARGIN_EN
        margin_d = margin_q;
`endif
        if (!stall) begin
            for (int l = 0; l < DEPTH; l++) begin
                vld_d[l]   = src_vld[l];
                patch_d[l] = src_patch[l];
                path_d[l]  = (src_path[l] << 1) | DEPTH'(go_right[l]);
`ifdef KD_PATH_MARGIN_EN
                margin_d[l] = next_margin[l];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            load_done_q <= 1'b0;
            vld_q       <= '0;
            for (int l = 0; l < DEPTH; l++) begin
                path_q[l] <= '0;
`ifdef KD_PATH_MARGIN_EN
                margin_q[l] <= '1;
`endif
            end
        end else begin
            wptr_q      <= wptr_d;
            load_done_q <= load_done_d;
            vld_q       <= vld_d;
            path_q      <= path_d;
`ifdef KD_PATH_MARGIN_EN
            margin_q    <= margin_d;
`endif
        end
    end

    // NOTE: node table and patch payload carry no reset; they are qualified by load_done and the stage valids.
    always_ff @(posedge clk) begin
        node_q  <= node_d;
        patch_q <= patch_d;
    end

endmodule

// File: tb/tb_kd_tree_traverse_pipe.sv
// Scoreboard bench for kd_tree_traverse_pipe (DEPTH=3, DIM=2, ELEM_WIDTH=8, IDX_W=1).
module tb_kd_tree_traverse_pipe;
    localparam int DEPTH = 3;
    localparam int DIM   = 2;
    localparam int EW    = 8;
    localparam int IDX_W = 1;
    localparam int PW    = DIM * EW;
    localparam int NW    = IDX_W + EW;
    localparam int NODES = (1 << DEPTH) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_restart = 1'b0;
    logic          wr_en = 1'b0;
    logic [NW-1:0] wr_data = '0;
    logic          load_done;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_patch = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DEPTH-1:0] out_leaf;
`ifdef KD_PATH_MARGIN_EN
    logic [EW-1:0] out_margin;
`endif

    kd_tree_traverse_pipe #(.DEPTH(DEPTH), .DIM(DIM), .ELEM_WIDTH(EW), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .load_restart(load_restart), .wr_en(wr_en), .wr_data(wr_data),
        .load_done(load_done), .in_valid(in_valid), .in_ready(in_ready), .in_patch(in_patch),
        .out_valid(out_valid), .out_ready(out_ready), .out_leaf(out_leaf)
`ifdef KD_PATH_MARGIN_EN
        , .out_margin(out_margin)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int leaf;
        int margin;
        int acc_cyc;
        int stalls;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    bit   presented = 0;

    // Reference tree as the loader should see it, plus the target tree for the next load.
    int m_dim [NODES];
    int m_med [NODES];
    int m_wptr = 0;
    bit m_done = 0;
    int t_dim [NODES];
    int t_med [NODES];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Walk the heap from the root: children of i are 2i+1 (left) and 2i+2 (right).
    function automatic void model_eval(input logic [PW-1:0] p, output int leaf, output int margin);
        int idx = 0;
        leaf   = 0;
        margin = (1 << EW) - 1;
        for (int l = 0; l < DEPTH; l++) begin
            int d   = m_dim[idx];
            int med = m_med[idx];
            int e;
            int right = 0;
            int diff  = (1 << EW) - 1;
            if (d < DIM) begin
                e     = int'(p[d*EW +: EW]);
                right = (e > med) ? 1 : 0;
                diff  = (e > med) ? e - med : med - e;
            end
            leaf   = leaf * 2 + right;
            margin = (diff < margin) ? diff : margin;
            idx    = 2 * idx + 1 + right;
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pushes expectations at each handshake, pops and compares at each output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            presented = 0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 0);
                end else begin
                    if (!presented && sb[0].stalls == stall_cnt)
                        check("latency", cyc - sb[0].acc_cyc, DEPTH);
                    presented = 1;
                    check("out_leaf", out_leaf, sb[0].leaf);
`ifdef KD_PATH_MARGIN_EN
                    check("out_margin", out_margin, sb[0].margin);
`endif
                    if (out_ready) begin
                        void'(sb.pop_front());
                        presented = 0;
                    end
                end
                if (!out_ready) begin
                    check("in_ready_during_stall", in_ready, 0);
                    stall_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                exp_t x;
                model_eval(in_patch, x.leaf, x.margin);
                x.acc_cyc = cyc;
                x.stalls  = stall_cnt;
                sb.push_back(x);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input bit restart, input bit we, input int dim, input int med);
        load_restart = restart;
        wr_en        = we;
        wr_data      = {IDX_W'(dim), EW'(med)};
        if (restart) begin
            m_wptr = 0;
            m_done = 0;
        end else if (we && !m_done) begin
            m_dim[m_wptr] = dim;
            m_med[m_wptr] = med;
            if (m_wptr == NODES - 1) m_done = 1;
            else                     m_wptr++;
        end
        step();
        load_restart = 1'b0;
        wr_en        = 1'b0;
    endtask

    task automatic load_tree();
        for (int k = 0; k < NODES; k++) begin
            check("load_done_during_load", load_done, 0);
            drive_write(0, 1, t_dim[k], t_med[k]);
        end
        check("load_done_after_last", load_done, 1);
    endtask

    task automatic query(input int e0, input int e1);
        int n = 0;
        in_valid = 1'b1;
        in_patch = {EW'(e1), EW'(e0)};
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("query_accept_timeout", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic set_tree2();
        for (int k = 0; k < NODES; k++) begin
            t_dim[k] = 0;
            t_med[k] = 0;
        end
        t_dim[0] = 0; t_med[0] = 100;
        t_dim[2] = 1; t_med[2] = 30;
        t_dim[6] = 0; t_med[6] = 150;
    endtask

    logic [PW-1:0] pats [5];

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_leaf", out_leaf, 0);
        check("rst_load_done", load_done, 0);
`ifdef KD_PATH_MARGIN_EN
        check("rst_out_margin", out_margin, (1 << EW) - 1);
`endif
        rst_n = 1'b1;
        step();

        // Queries offered before any load must not be accepted
        in_valid = 1'b1;
        in_patch = {8'd5, 8'd5};
        for (int i = 0; i < 3; i++) begin
            check("in_ready_before_load", in_ready, 0);
            step();
        end
        in_valid = 1'b0;

        // Uniform tree {0,100}: below, above and equal to the median
        for (int k = 0; k < NODES; k++) begin
            t_dim[k] = 0;
            t_med[k] = 100;
        end
        load_tree();
        query(50, 0);
        drain();
        query(200, 0);
        query(100, 0);
        drain();

        // Mixed tree: right, right, left
        drive_write(1, 0, 0, 0);
        check("load_done_after_restart", load_done, 0);
        set_tree2();
        load_tree();
        query(120, 40);
        drain();

        // Writes past the last node are dropped
        drive_write(0, 1, 1, 255);
        drive_write(0, 1, 1, 255);
        check("load_done_after_extra_writes", load_done, 1);
        query(160, 40);
        query(120, 40);
        query(90, 200);
        drain();

        // Back-to-back queries with out_ready low for loop cycles 4..7
        pats[0] = {8'd40, 8'd120};
        pats[1] = {8'd10, 8'd160};
        pats[2] = {8'd0,  8'd100};
        pats[3] = {8'd31, 8'd101};
        pats[4] = {8'd30, 8'd255};
        begin
            int sent = 0;
            for (int i = 0; i < 20; i++) begin
                out_ready = !(i >= 4 && i <= 7);
                if (sent < 5) begin
                    in_valid = 1'b1;
                    in_patch = pats[sent];
                    if (in_ready) sent++;
                end else begin
                    in_valid = 1'b0;
                end
                step();
            end
            in_valid = 1'b0;
            check("backpressure_all_sent", sent, 5);
        end
        drain();

        // Restart with a same-cycle write: write dropped, new tree takes effect
        drive_write(1, 1, 1, 77);
        check("restart_load_done", load_done, 0);
        check("restart_in_ready", in_ready, 0);
        t_dim = '{1, 0, 1, 0, 0, 1, 1};
        t_med = '{60, 20, 200, 5, 90, 128, 64};
        load_tree();
        query(10, 70);
        query(100, 30);
        query(250, 250);
        query(20, 60);
        drain();

        // Randomised traffic over a random tree, with random gaps and backpressure
        drive_write(1, 0, 0, 0);
        for (int k = 0; k < NODES; k++) begin
            t_dim[k] = $urandom_range(0, 1);
            t_med[k] = $urandom_range(0, 255);
        end
        load_tree();
        for (int i = 0; i < 300; i++) begin
            int e0 = ($urandom_range(0, 3) == 0) ? t_med[$urandom_range(0, NODES - 1)] : $urandom_range(0, 255);
            int e1 = ($urandom_range(0, 3) == 0) ? t_med[$urandom_range(0, NODES - 1)] : $urandom_range(0, 255);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_patch  = {EW'(e1), EW'(e0)};
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Reset with two queries in flight
        in_valid = 1'b1;
        in_patch = {8'd1, 8'd2};
        step();
        in_patch = {8'd200, 8'd201};
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        m_wptr = 0;
        m_done = 0;
        step();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_load_done", load_done, 0);
        rst_n = 1'b1;
        repeat (8) step();
        check("post_rst_no_stale", out_valid, 0);
        set_tree2();
        load_tree();
        query(120, 40);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
